// File: rtl/rsa_pkg.sv
// rsa_pkg -- shared definitions for the modular exponentiation engine.
//   KEY_W_DEF / EXP_W_DEF : default operand and exponent widths
//   MM_CYCLES             : cycles per modular multiply at the default key width
//   state_t               : engine FSM state encoding
package rsa_pkg;

   localparam int KEY_W_DEF = 128;
   localparam int EXP_W_DEF = 32;
   localparam int MM_CYCLES = KEY_W_DEF + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SQR,
      MUL,
      NEXT,
      FIN
   } state_t;

endpackage

// File: rtl/modmul_serial.sv
// modmul_serial -- bit-serial interleaved (Blakley) modular multiplier.
// Computes result = a*b mod n, with a, b < n assumed.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        load a, b, n and begin (one cycle)
//   a, b, n      operands, sampled on the edge that sees start
//   done         high in the final iteration cycle; result valid alongside
//   result       product, combinational from the final iteration
// Latency: the start cycle plus KEY_W iteration cycles; done is high in the
// last of these, so the caller can capture result and issue the next start
// on the same edge.
module modmul_serial
   import rsa_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [KEY_W-1:0] a,
   input  logic [KEY_W-1:0] b,
   input  logic [KEY_W-1:0] n,
   output logic             done,
   output logic [KEY_W-1:0] result
);

   localparam int CW = $clog2(KEY_W + 1);

   logic [KEY_W-1:0] a_r, b_r, n_r;
   logic [KEY_W+1:0] p, t, t1, t2;
   logic [CW-1:0]    cnt;

   // 2P + b < 3n, so two conditional subtracts bring it back below n.
   always_comb begin
      t  = (p << 1) + (a_r[KEY_W-1] ? {2'b00, b_r} : '0);
      t1 = (t  >= {2'b00, n_r}) ? t  - {2'b00, n_r} : t;
      t2 = (t1 >= {2'b00, n_r}) ? t1 - {2'b00, n_r} : t1;
   end

   assign done   = (cnt == CW'(1));
   assign result = t2[KEY_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r <= '0;
         b_r <= '0;
         n_r <= '0;
         p   <= '0;
         cnt <= '0;
      end else if (start) begin
         a_r <= a;
         b_r <= b;
         n_r <= n;
         p   <= '0;
         cnt <= CW'(KEY_W);
      end else if (cnt != '0) begin
         p   <= t2;
         a_r <= {a_r[KEY_W-2:0], 1'b0};
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/modexp_engine.sv
// modexp_engine -- left-to-right binary modular exponentiation, result = msg^e mod n.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        request pulse, sampled only in IDLE
//   n, e, msg    modulus, exponent, base; latched on the accepting edge
//   busy         high from acceptance until done
//   done         one-cycle completion pulse
//   err          operand error (n<2 or msg>=n), valid with done
//   result       msg^e mod n (0 on error), held until the next run finishes
// Build option: MODEXP_LZ_SKIP_EN skips the squarings for exponent bits above
// the highest set bit (e=0 finishes straight from LOAD).
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | operand check, pick first exponent bit; first square already issued
// SQR   | acc = acc*acc mod n in progress
// MUL   | acc = acc*msg mod n in progress
// NEXT  | step to the next exponent bit; its square is issued here
// FIN   | publish result/err, pulse done
module modexp_engine
   import rsa_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF,
   parameter int EXP_W = EXP_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [KEY_W-1:0] n,
   input  logic [EXP_W-1:0] e,
   input  logic [KEY_W-1:0] msg,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [KEY_W-1:0] result
);

   localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

   state_t           state;
   logic [KEY_W-1:0] n_r, m_r, acc;
   logic [EXP_W-1:0] e_r;
   logic [IW-1:0]    idx;
   logic             err_pend;
   logic             mm_start, mm_done;
   logic [KEY_W-1:0] mm_b, mm_result;

   // The multiply for each state is launched one cycle ahead (in LOAD/NEXT
   // for squares, on the SQR->MUL edge for multiplies) so NEXT costs nothing.
   assign mm_b = (state == MUL) ? m_r : acc;

   modmul_serial #(.KEY_W(KEY_W)) u_mm (
      .clk    (clk),
      .reset  (reset),
      .start  (mm_start),
      .a      (acc),
      .b      (mm_b),
      .n      (n_r),
      .done   (mm_done),
      .result (mm_result)
   );

`ifdef MODEXP_LZ_SKIP_EN
   logic [IW-1:0] top_bit;
   always_comb begin
      top_bit = '0;
      for (int k = 0; k < EXP_W; k++)
         if (e_r[k]) top_bit = IW'(k);
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         n_r      <= '0;
         m_r      <= '0;
         e_r      <= '0;
         acc      <= '0;
         idx      <= '0;
         err_pend <= 1'b0;
         mm_start <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         result   <= '0;
      end else begin
         done     <= 1'b0;
         mm_start <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  n_r      <= n;
                  m_r      <= msg;
                  e_r      <= e;
                  acc      <= KEY_W'(1);
                  err_pend <= 1'b0;
                  busy     <= 1'b1;
                  mm_start <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               if (n_r < KEY_W'(2) || m_r >= n_r) begin
                  err_pend <= 1'b1;
                  state    <= FIN;
               end
`ifdef MODEXP_LZ_SKIP_EN
               else if (e_r == '0) begin
                  state <= FIN;
               end else begin
                  idx   <= top_bit;
                  state <= SQR;
               end
`else
               else begin
                  idx   <= IW'(EXP_W - 1);
                  state <= SQR;
               end
`endif
            end
            SQR: begin
               if (mm_done) begin
                  acc <= mm_result;
                  if (e_r[idx]) begin
                     mm_start <= 1'b1;
                     state    <= MUL;
                  end else begin
                     mm_start <= (idx != '0);
                     state    <= NEXT;
                  end
               end
            end
            MUL: begin
               if (mm_done) begin
                  acc      <= mm_result;
                  mm_start <= (idx != '0);
                  state    <= NEXT;
               end
            end
            NEXT: begin
               if (idx != '0) begin
                  idx   <= idx - 1'b1;
                  state <= SQR;
               end else begin
                  state <= FIN;
               end
            end
            FIN: begin
               result <= err_pend ? '0 : acc;
               err    <= err_pend;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_modexp_engine.sv
module tb_modexp_engine;
   import rsa_pkg::*;

   localparam int K     = KEY_W_DEF;
   localparam int E     = EXP_W_DEF;
   localparam int LIMIT = 20000;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [K-1:0] n, msg;
   logic [E-1:0] e;
   logic         busy, done, err;
   logic [K-1:0] result;

   int checks = 0;
   int errors = 0;

   modexp_engine #(.KEY_W(K), .EXP_W(E)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .n      (n),
      .e      (e),
      .msg    (msg),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .result (result)
   );

   always #5 clk = ~clk;

   // Reference: right-to-left square-and-multiply with wide arithmetic.
   function automatic logic [K-1:0] ref_modexp(input logic [K-1:0] m, input logic [E-1:0] ee,
                                               input logic [K-1:0] nn);
      logic [2*K-1:0] acc, base, nw;
      if (nn < 2 || m >= nn) return '0;
      nw   = {{K{1'b0}}, nn};
      acc  = 1;
      base = {{K{1'b0}}, m};
      for (int i = 0; i < E; i++) begin
         if (ee[i]) acc = (acc * base) % nw;
         base = (base * base) % nw;
      end
      acc = acc % nw;
      return acc[K-1:0];
   endfunction

   function automatic int ref_lat(input logic [K-1:0] m, input logic [E-1:0] ee,
                                  input logic [K-1:0] nn);
      int span;
      if (nn < 2 || m >= nn) return 2;
`ifdef MODEXP_LZ_SKIP_EN
      span = 0;
      for (int i = 0; i < E; i++) if (ee[i]) span = i + 1;
`else
      span = E;
`endif
      return 2 + MM_CYCLES * (span + $countones(ee));
   endfunction

   // Stimulus only: issue a request now, return at #1 after the done edge.
   task automatic run_op(input logic [K-1:0] m, input logic [E-1:0] ee, input logic [K-1:0] nn,
                         output int lat, output bit to);
      msg = m; e = ee; n = nn; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      to  = 1'b1;
      while (lat < LIMIT) begin
         @(posedge clk); #1;
         lat++;
         if (done) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; n = '0; e = '0; msg = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %0b want 0", done); end
      checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err got %0b want 0", err); end
      checks++; if (result !== '0)   begin errors++; $display("FAIL reset_result got %0h want 0", result); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_known();
      int lat, want_lat; bit to;
`ifdef MODEXP_LZ_SKIP_EN
      want_lat = 905;
`else
      want_lat = 4517;
`endif
      run_op(K'(4), E'(13), K'(497), lat, to);
      checks++; if (to !== 1'b0)          begin errors++; $display("FAIL known_timeout got %0b want 0", to); end
      checks++; if (result !== K'(445))   begin errors++; $display("FAIL known_result got %0d want 445", result); end
      checks++; if (err !== 1'b0)         begin errors++; $display("FAIL known_err got %0b want 0", err); end
      checks++; if (lat != want_lat)      begin errors++; $display("FAIL known_latency got %0d want %0d", lat, want_lat); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL known_busy_at_done got %0b want 0", busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0)        begin errors++; $display("FAIL known_done_pulse got %0b want 0", done); end
      checks++; if (result !== K'(445))   begin errors++; $display("FAIL known_result_held got %0d want 445", result); end
   endtask

   task automatic test_operand_err();
      int lat; bit to;
      run_op(K'(500), E'(3), K'(497), lat, to);
      checks++; if (to !== 1'b0)      begin errors++; $display("FAIL msg_ge_n_timeout got %0b want 0", to); end
      checks++; if (err !== 1'b1)     begin errors++; $display("FAIL msg_ge_n_err got %0b want 1", err); end
      checks++; if (result !== '0)    begin errors++; $display("FAIL msg_ge_n_result got %0h want 0", result); end
      checks++; if (lat != 2)         begin errors++; $display("FAIL msg_ge_n_latency got %0d want 2", lat); end
      run_op(K'(0), E'(3), K'(1), lat, to);
      checks++; if (to !== 1'b0)      begin errors++; $display("FAIL n_one_timeout got %0b want 0", to); end
      checks++; if (err !== 1'b1)     begin errors++; $display("FAIL n_one_err got %0b want 1", err); end
      checks++; if (result !== '0)    begin errors++; $display("FAIL n_one_result got %0h want 0", result); end
      checks++; if (lat != 2)         begin errors++; $display("FAIL n_one_latency got %0d want 2", lat); end
   endtask

   task automatic test_zero_exp();
      int lat, want_lat; bit to;
`ifdef MODEXP_LZ_SKIP_EN
      want_lat = 2;
`else
      want_lat = 4130;
`endif
      run_op(K'(7), E'(0), K'(11), lat, to);
      checks++; if (to !== 1'b0)      begin errors++; $display("FAIL zero_exp_timeout got %0b want 0", to); end
      checks++; if (result !== K'(1)) begin errors++; $display("FAIL zero_exp_result got %0h want 1", result); end
      checks++; if (err !== 1'b0)     begin errors++; $display("FAIL zero_exp_err got %0b want 0", err); end
      checks++; if (lat != want_lat)  begin errors++; $display("FAIL zero_exp_latency got %0d want %0d", lat, want_lat); end
   endtask

   task automatic test_mersenne();
      int lat; bit to;
      logic [K-1:0] nm;
      nm = {1'b0, {(K-1){1'b1}}};
      run_op(K'(2), E'(127), nm, lat, to);
      checks++; if (to !== 1'b0)      begin errors++; $display("FAIL mersenne_timeout got %0b want 0", to); end
      checks++; if (result !== K'(1)) begin errors++; $display("FAIL mersenne_result got %0h want 1", result); end
      checks++; if (err !== 1'b0)     begin errors++; $display("FAIL mersenne_err got %0b want 0", err); end
      checks++; if (lat != ref_lat(K'(2), E'(127), nm))
         begin errors++; $display("FAIL mersenne_latency got %0d want %0d", lat, ref_lat(K'(2), E'(127), nm)); end
   endtask

   task automatic test_busy_ignore();
      int lat, want_lat; bit to;
      want_lat = ref_lat(K'(4), E'(13), K'(497));
      msg = K'(4); e = E'(13); n = K'(497); start = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got %0b want 1", busy); end
      lat = 0;
      for (int k = 0; k < 5; k++) begin
         msg = K'(3); e = E'(5); n = K'(11); start = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      to = 1'b1;
      while (lat < LIMIT) begin
         @(posedge clk); #1;
         lat++;
         if (done) begin to = 1'b0; break; end
      end
      checks++; if (to !== 1'b0)        begin errors++; $display("FAIL ignore_timeout got %0b want 0", to); end
      checks++; if (result !== K'(445)) begin errors++; $display("FAIL ignore_result got %0d want 445", result); end
      checks++; if (err !== 1'b0)       begin errors++; $display("FAIL ignore_err got %0b want 0", err); end
      checks++; if (lat != want_lat)    begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, want_lat); end
   endtask

   task automatic test_reset_midrun();
      int lat, abort_at, seen_done; bit to;
`ifdef MODEXP_LZ_SKIP_EN
      abort_at = 500;
`else
      abort_at = 1000;
`endif
      msg = K'(4); e = E'(13); n = K'(497); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (abort_at) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL abort_done got %0b want 0", done); end
      checks++; if (err !== 1'b0)   begin errors++; $display("FAIL abort_err got %0b want 0", err); end
      checks++; if (result !== '0)  begin errors++; $display("FAIL abort_result got %0h want 0", result); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen_done = 0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (done) seen_done++;
      end
      checks++; if (seen_done != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen_done); end
      run_op(K'(4), E'(13), K'(497), lat, to);
      checks++; if (to !== 1'b0)        begin errors++; $display("FAIL rerun_timeout got %0b want 0", to); end
      checks++; if (result !== K'(445)) begin errors++; $display("FAIL rerun_result got %0d want 445", result); end
      checks++; if (lat != ref_lat(K'(4), E'(13), K'(497)))
         begin errors++; $display("FAIL rerun_latency got %0d want %0d", lat, ref_lat(K'(4), E'(13), K'(497))); end
   endtask

   // Random operands issued back to back: each start goes in the cycle right
   // after the previous done, so the latency check also proves acceptance.
   task automatic test_back_to_back();
      int lat; bit to;
      logic [K-1:0] nn, mm, want;
      logic [E-1:0] ee;
      for (int r = 0; r < 4; r++) begin
         nn = {$urandom, $urandom, $urandom, $urandom};
         nn[K-1] = 1'b0;
         nn = nn | K'(2);
         if (r == 2) mm = nn + K'($urandom_range(0, 100));
         else        mm = {$urandom, $urandom, $urandom, $urandom} % nn;
         ee = E'($urandom);
         want = ref_modexp(mm, ee, nn);
         run_op(mm, ee, nn, lat, to);
         checks++; if (to !== 1'b0)  begin errors++; $display("FAIL rand%0d_timeout got %0b want 0", r, to); end
         checks++; if (result !== want)
            begin errors++; $display("FAIL rand%0d_result got %0h want %0h", r, result, want); end
         checks++; if (err !== (r == 2))
            begin errors++; $display("FAIL rand%0d_err got %0b want %0b", r, err, (r == 2)); end
         checks++; if (lat != ref_lat(mm, ee, nn))
            begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", r, lat, ref_lat(mm, ee, nn)); end
      end
   endtask

   initial begin
      test_reset();
      test_known();
      test_operand_err();
      test_zero_exp();
      test_mersenne();
      test_busy_ignore();
      test_reset_midrun();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/modexp_engine.md
MODEXP_ENGINE -- requirements
Module: modexp_engine

Interface
REQ-001 SHALL have parameter KEY_W, default 128, width of modulus, message and result.
REQ-002 SHALL have parameter EXP_W, default 32, width of public exponent.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port n  input  KEY_W  modulus (public key n from key store).
REQ-007 SHALL have port e  input  EXP_W  exponent (public key e from key store).
REQ-008 SHALL have port msg  input  KEY_W  base operand m.
REQ-009 SHALL have port busy  output  1  high from start acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  operand error flag, valid with done, held until next accept.
REQ-012 SHALL have port result  output  KEY_W  m^e mod n, held until next accept.

Function
REQ-013 SHALL latch n, e, msg on the accepting edge; later input changes have no effect on the run.
REQ-014 SHALL ignore start while busy=1.
REQ-015 SHALL use FSM states IDLE, LOAD, SQR, MUL, NEXT, FIN; IDLE->LOAD on start, LOAD->SQR, SQR->MUL if e[i]=1 else NEXT, MUL->NEXT, NEXT->SQR if i>0 else FIN, FIN->IDLE.
REQ-016 SHALL compute left-to-right binary exponentiation: acc=1; for i=EXP_W-1..0: acc=acc*acc mod n; if e[i] acc=acc*m mod n.
REQ-017 SHALL perform each modular multiply by interleaved shift-add (Blakley): KEY_W iterations MSB-first, P=2P+a_j*b, then at most two conditional subtracts of n, internal width KEY_W+2.
REQ-018 SHALL take exactly 129 cycles per modular multiply (128 iterations + 1 hand-off).
REQ-019 SHALL assert done exactly L = 2 + 129*(EXP_W + popcount(e)) cycles after the accepting edge (macro off).
REQ-020 SHALL, if n<2 or msg>=n, skip to FIN: done 2 cycles after accept, err=1, result=0.
REQ-021 SHALL, for e=0 and valid operands, return result=1, err=0.
REQ-022 SHALL drive busy=0 in the cycle done=1 and accept a new start in the following cycle.
REQ-023 SHALL update result only in FIN.

Reset
REQ-024 SHALL, on reset asserted (any state, mid-operation included), go to IDLE immediately with busy=0, done=0, err=0, result=0.
REQ-025 SHALL NOT emit done for a run aborted by reset.

Configuration
REQ-026 SHALL, with MODEXP_LZ_SKIP_EN defined, skip SQR/MUL for exponent bits above the highest set bit: L = 2 + 129*(EXP_W - lzc(e) + popcount(e)); e=0 gives L=2, result=1.
REQ-027 SHALL, without MODEXP_LZ_SKIP_EN, process all EXP_W bits (latency per REQ-019).

Structure
REQ-028 SHALL place KEY_W/EXP_W defaults, MM_CYCLES=129 and the FSM state enum in shared package rsa_pkg.
REQ-029 SHALL implement the Blakley multiplier as sub-module modmul_serial (start/done handshake, operands a, b, n, 129-cycle fixed latency).

Verification
REQ-030 SHALL test msg=4, e=13, n=497 -> result=445, err=0, done at cycle 4517 (macro off) / 905 (macro on).
REQ-031 SHALL test msg=2, e=127, n=2^127-1 -> result=1, err=0.
REQ-032 SHALL test msg=500, n=497, e=3 -> err=1, result=0, done 2 cycles after accept; also n=1 -> err=1.
REQ-033 SHALL test e=0, msg=7, n=11 -> result=1; done at cycle 4130 (macro off) / 2 (macro on).
REQ-034 SHALL test reset pulsed mid-run (cycle 1000 of REQ-030 case) -> outputs zero, no done, fresh start gives 445.
REQ-035 SHALL test start re-asserted while busy and inputs changed after accept -> ignored, result still 445.
